// File: rtl/instr_fetch.sv
// Instruction fetch stage: a BOOT/FETCH/ISSUE/TRAP sequencer that owns the PC,
// requests one word from instruction memory, and presents it to decode.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        misaligned
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        misaligned_q;
  logic        imem_req_q;
  logic        instr_valid_q;

  logic [31:0] pc_plus4;
  logic [31:0] pc_d;

  assign pc_plus4 = pc_q + 32'd4;

  // jalr clears bit 0 of its target; the reserved encoding falls back to PC+4
  always_comb begin
    pc_d = pc_plus4;
    case (PCSrc)
      2'b01:   pc_d = PCTarget;
      2'b10:   pc_d = ALUResult & ~32'd1;
      default: pc_d = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      misaligned_q  <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= FETCH;
          imem_req_q <= 1'b1;
        end
        FETCH: begin
          if (imem_ready) begin
            instr_q       <= imem_rdata;
            state_q       <= ISSUE;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          // PCSrc/PCTarget/ALUResult only matter on the edge the instruction retires
          if (!stall) begin
            pc_q          <= pc_d;
            instr_valid_q <= 1'b0;
            if (pc_d[1:0] != 2'b00) begin
              state_q      <= TRAP;
              misaligned_q <= 1'b1;
            end else begin
              state_q    <= FETCH;
              imem_req_q <= 1'b1;
            end
          end
        end
        TRAP: begin
          state_q       <= TRAP;
          imem_req_q    <= 1'b0;
          instr_valid_q <= 1'b0;
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign Instr       = instr_q;
  assign PC          = pc_q;
  assign PCPlus4     = pc_plus4;
  assign instr_valid = instr_valid_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a memory model plus an abstract
// "expected PC / expected instruction" model drive and check every cycle.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        misaligned;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_instr;
  logic [98:0] obs;
  logic [98:0] exp_v;

  instr_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .ALUResult(ALUResult), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4), .instr_valid(instr_valid),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a5a, a[31:16]} ^ 32'h0000_0033;
  endfunction

  // Architectural next-PC rule, written from the instruction-set semantics
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input int src,
                                           input logic [31:0] tgt, input logic [31:0] alu);
    if (src == 1) return tgt;
    if (src == 2) return alu - (alu % 2);
    return pc + 32'd4;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset mid-cycle, check outputs before any clock edge, then release
  task automatic apply_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    obs   = {imem_req, instr_valid, misaligned, PC, Instr, PCPlus4};
    exp_v = {1'b0, 1'b0, 1'b0, RST_PC, NOP, RST_PC + 32'd4};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s_async act=%h exp=%h", tag, obs, exp_v);
    end
    imem_ready = 1'b1;
    stall      = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({imem_req, instr_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s_boot act=%b exp=00", tag, {imem_req, instr_valid});
    end
    exp_pc    = RST_PC;
    exp_instr = NOP;
    tick();
    $display("reset %s released pc=%h", tag, exp_pc);
  endtask

  // Called in FETCH; memory answers after `waits` not-ready cycles
  task automatic fetch_issue(input int waits, input string tag);
    for (int w = 0; w <= waits; w++) begin
      imem_ready = (w == waits);
      imem_rdata = (w == waits) ? mem_word(exp_pc) : $urandom;
      stall      = 1'($urandom);
      obs   = {imem_req, instr_valid, misaligned, imem_addr, PC, Instr};
      exp_v = {1'b1, 1'b0, 1'b0, exp_pc, exp_pc, exp_instr};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s_fetch w=%0d act=%h exp=%h", tag, w, obs, exp_v);
      end
      tick();
    end
    exp_instr = mem_word(exp_pc);
    obs   = {imem_req, instr_valid, misaligned, PC, Instr, PCPlus4};
    exp_v = {1'b0, 1'b1, 1'b0, exp_pc, exp_instr, exp_pc + 32'd4};
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s_issue act=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  // Called in ISSUE; holds for `stalls` cycles with decoy control, then retires
  task automatic retire(input int stalls, input int src, input logic [31:0] tgt,
                        input logic [31:0] alu, input string tag);
    logic [31:0] nxt;
    for (int s = 0; s < stalls; s++) begin
      stall      = 1'b1;
      PCSrc      = (s % 2 == 0) ? 2'b01 : 2'($urandom);
      PCTarget   = $urandom;
      ALUResult  = $urandom;
      imem_ready = 1'($urandom);
      imem_rdata = $urandom;
      tick();
      obs   = {imem_req, instr_valid, misaligned, PC, Instr, PCPlus4};
      exp_v = {1'b0, 1'b1, 1'b0, exp_pc, exp_instr, exp_pc + 32'd4};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s_stall s=%0d act=%h exp=%h", tag, s, obs, exp_v);
      end
    end
    stall     = 1'b0;
    PCSrc     = 2'(src);
    PCTarget  = tgt;
    ALUResult = alu;
    tick();
    nxt = ref_next(exp_pc, src, tgt, alu);
    $display("retire %s pc=%h src=%0d next=%h", tag, exp_pc, src, nxt);
    exp_pc = nxt;
    if (nxt[1:0] != 2'b00) begin
      obs   = {imem_req, instr_valid, misaligned, 32'h0, PC, 32'h0};
      exp_v = {1'b0, 1'b0, 1'b1, 32'h0, nxt, 32'h0};
    end else begin
      obs   = {imem_req, instr_valid, misaligned, imem_addr, PC, Instr};
      exp_v = {1'b1, 1'b0, 1'b0, nxt, nxt, exp_instr};
    end
    n_cmp++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s_retire act=%h exp=%h", tag, obs, exp_v);
    end
  endtask

  task automatic test_reset();
    apply_reset("reset");
    fetch_issue(0, "reset");
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      retire(0, 0, 32'h0, 32'h0, "seq");
      fetch_issue(0, "seq");
    end
  endtask

  task automatic test_redirect();
    apply_reset("redir");
    fetch_issue(0, "redir");
    for (int i = 0; i < 4; i++) begin
      retire(0, 0, 32'h0, 32'h0, "redir_step");
      fetch_issue(0, "redir_step");
    end
    retire(0, 1, 32'h0000_0040, 32'hdead_beef, "redir_jal");
    fetch_issue(0, "redir_jal");
    retire(0, 2, 32'h1234_5678, 32'h0000_0081, "redir_jalr");
    fetch_issue(1, "redir_jalr");
    retire(0, 3, 32'h1234_5678, 32'h0000_0101, "redir_rsvd");
    fetch_issue(0, "redir_rsvd");
  endtask

  task automatic test_wait_ready();
    retire(0, 0, 32'h0, 32'h0, "wait");
    fetch_issue(5, "wait");
  endtask

  task automatic test_stall();
    retire(3, 1, 32'h0000_0200, 32'h0, "stall");
    fetch_issue(0, "stall");
  endtask

  task automatic test_wrap();
    retire(0, 1, 32'hFFFF_FFFC, 32'h0, "wrap_jmp");
    fetch_issue(0, "wrap_jmp");
    retire(0, 0, 32'h0, 32'h0, "wrap");
    fetch_issue(0, "wrap");
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    logic [31:0] alu;
    for (int i = 0; i < 40; i++) begin
      tgt = $urandom;
      alu = $urandom;
      tgt[1:0] = 2'b00;
      alu[1]   = 1'b0;
      retire($urandom_range(0, 3), $urandom_range(0, 3), tgt, alu, "rand");
      fetch_issue($urandom_range(0, 3), "rand");
    end
  endtask

  task automatic trap_hold(input string tag);
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      stall      = 1'b0;
      PCSrc      = 2'b01;
      PCTarget   = $urandom;
      tick();
      obs   = {imem_req, instr_valid, misaligned, 32'h0, PC, 32'h0};
      exp_v = {1'b0, 1'b0, 1'b1, 32'h0, exp_pc, 32'h0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s_hold i=%0d act=%h exp=%h", tag, i, obs, exp_v);
      end
    end
  endtask

  task automatic test_trap();
    retire(1, 1, 32'h0000_0042, 32'h0, "trap_jal");
    trap_hold("trap_jal");
    apply_reset("trap_rst");
    fetch_issue(0, "trap_rst");
    retire(0, 2, 32'h0, 32'h0000_0087, "trap_jalr");
    trap_hold("trap_jalr");
  endtask

  task automatic test_reset_mid_fetch();
    apply_reset("mid");
    fetch_issue(0, "mid");
    for (int i = 0; i < 8; i++) begin
      retire(0, 0, 32'h0, 32'h0, "mid_step");
      if (i < 7) fetch_issue(0, "mid_step");
    end
    imem_ready = 1'b0;
    tick();
    n_cmp++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h0000_0020}) begin
      n_fail++;
      $display("FAIL mid_pre act=%h exp=%h", {imem_req, imem_addr}, {1'b1, 32'h0000_0020});
    end
    apply_reset("mid_fetch");
    fetch_issue(0, "mid_restart");
  endtask

  initial begin
    rst_n      = 1'b1;
    PCSrc      = 2'b00;
    PCTarget   = 32'h0;
    ALUResult  = 32'h0;
    stall      = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0;
    exp_pc     = RST_PC;
    exp_instr  = NOP;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_redirect();
    test_wait_ready();
    test_stall();
    test_wrap();
    test_random();
    test_trap();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
